// File: rtl/rgmii_phy_side_if.sv
// ---------------------------------------------------------------------------
// rgmii_phy_side_if
//
// PHY-side endpoint of an RGMII link, running entirely in the 125 MHz clk
// domain. The DDR pins are already split into rising (_1) and falling (_2)
// halves by external iddr/oddr primitives.
//
//   TX direction (MAC -> PHY core):
//     1G     : one byte per cycle, {txd_2, txd_1}, en = ctl_1, er = ctl_1^ctl_2.
//     10/100 : the MAC's slow TXC is sampled on rgmii_txc_1; one nibble is
//              captured per TXC rising edge and nibble pairs are assembled
//              into bytes, presented with a one-cycle phy_tx_valid strobe.
//   RX direction (PHY core -> MAC):
//     1G     : one byte accepted every cycle, split across the two halves.
//     10/100 : one byte accepted every two RXC periods, one nibble per
//              period, RXC generated from a period counter.
//     Idle bytes (dv=0, er=0) carry RGMII in-band status on RD.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   speed[1:0]               10=1G, 01=100M, 00=10M, 11 behaves as 1G
//   link_up, full_duplex     in-band status sources
//   rgmii_txc_1              MAC TXC, rising-half sample
//   rgmii_txd_1/_2[3:0]      MAC TXD halves
//   rgmii_tx_ctl_1/_2        MAC TX_CTL halves
//   phy_txd[7:0], phy_tx_en, phy_tx_er, phy_tx_valid
//                            decoded byte toward the PHY core
//   phy_rxd[7:0], phy_rx_dv, phy_rx_er
//                            byte from the PHY core
//   phy_rx_ready             byte on phy_rx* is taken this cycle
//   rgmii_rxc_1/_2           RXC halves to the oddr
//   rgmii_rd_1/_2[3:0]       RXD halves
//   rgmii_rx_ctl_1/_2        RX_CTL halves
// ---------------------------------------------------------------------------
module rgmii_phy_side_if (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic       link_up,
    input  logic       full_duplex,
    input  logic       rgmii_txc_1,
    input  logic [3:0] rgmii_txd_1,
    input  logic [3:0] rgmii_txd_2,
    input  logic       rgmii_tx_ctl_1,
    input  logic       rgmii_tx_ctl_2,
    output logic [7:0] phy_txd,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       phy_tx_valid,
    input  logic [7:0] phy_rxd,
    input  logic       phy_rx_dv,
    input  logic       phy_rx_er,
    output logic       phy_rx_ready,
    output logic       rgmii_rxc_1,
    output logic       rgmii_rxc_2,
    output logic [3:0] rgmii_rd_1,
    output logic [3:0] rgmii_rd_2,
    output logic       rgmii_rx_ctl_1,
    output logic       rgmii_rx_ctl_2
);

    // RXC period is 5 clocks at 100M and 50 clocks at 10M; the counter
    // runs 0..LAST and RXC is high for the first HIGH counts.
    localparam logic [5:0] LAST_100M = 6'd4;
    localparam logic [5:0] LAST_10M  = 6'd49;
    localparam logic [5:0] HIGH_100M = 6'd3;
    localparam logic [5:0] HIGH_10M  = 6'd25;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_LO   = 1'b1
    } tx_state_t;

    // sel_100m is spd_q[0]; only meaningful when not in 1G mode.
    function automatic logic [5:0] period_last(input logic sel_100m);
        return sel_100m ? LAST_100M : LAST_10M;
    endfunction

    function automatic logic [5:0] high_len(input logic sel_100m);
        return sel_100m ? HIGH_100M : HIGH_10M;
    endfunction

    function automatic logic [3:0] inband_status(input logic       fd,
                                                 input logic [1:0] spd,
                                                 input logic       link);
        return {fd, spd, link};
    endfunction

    // ---------------- control state ----------------
    logic [1:0] spd_q,        spd_d;
    logic [5:0] rx_cnt_q,     rx_cnt_d;
    logic       rx_ph_q,      rx_ph_d;
    logic       rx_ready_q,   rx_ready_d;
    logic       txc_prev_q,   txc_prev_d;
    logic       ctl1_prev_q,  ctl1_prev_d;
    tx_state_t  tx_state_q,   tx_state_d;

    // ---------------- data holding (no reset) ----------------
    logic [3:0] lo_nib_q,     lo_nib_d;
    logic       lo_er_q,      lo_er_d;
    logic [7:0] rxb_q,        rxb_d;
    logic       rxb_dv_q,     rxb_dv_d;
    logic       rxb_er_q,     rxb_er_d;

    // ---------------- registered outputs ----------------
    logic [7:0] phy_txd_q,    phy_txd_d;
    logic       phy_tx_en_q,  phy_tx_en_d;
    logic       phy_tx_er_q,  phy_tx_er_d;
    logic       phy_tx_vld_q, phy_tx_vld_d;
    logic       rxc_1_q,      rxc_1_d;
    logic       rxc_2_q,      rxc_2_d;
    logic [3:0] rd_1_q,       rd_1_d;
    logic [3:0] rd_2_q,       rd_2_d;
    logic       rx_ctl_1_q,   rx_ctl_1_d;
    logic       rx_ctl_2_q,   rx_ctl_2_d;

    logic       gig;
    logic       rx_boundary;
    logic       spd_chg;

    // ---------------- speed register and RX period counter ----------------
    always_comb begin
        gig = spd_q[1];

        // Speed may only change where a full RX byte period ends, so a
        // byte in flight is never split across two speeds.
        rx_boundary = gig || (rx_ph_q && (rx_cnt_q >= period_last(spd_q[0])));
        spd_d       = rx_boundary ? speed : spd_q;
        spd_chg     = (spd_d != spd_q);

        rx_cnt_d = rx_cnt_q;
        rx_ph_d  = rx_ph_q;
        if (gig) begin
            rx_cnt_d = 6'd0;
            rx_ph_d  = 1'b0;
        end else if (rx_cnt_q >= period_last(spd_q[0])) begin
            rx_cnt_d = 6'd0;
            rx_ph_d  = ~rx_ph_q;
        end else begin
            rx_cnt_d = rx_cnt_q + 6'd1;
        end

        if (spd_chg) begin
            rx_cnt_d = 6'd0;
            rx_ph_d  = 1'b0;
        end

        // Ready is registered, so it is predicted from the next state.
        rx_ready_d = spd_d[1] || ((rx_cnt_d == 6'd0) && !rx_ph_d);
    end

    // ---------------- RX encode ----------------
    logic [7:0] cur_rxd;
    logic       cur_dv;
    logic       cur_er;
    logic       rxc_hi;
    logic [3:0] cur_nib;
    logic [3:0] ib_nib;

    always_comb begin
        // The accepting cycle encodes straight from the inputs; the rest of
        // a 10/100 byte period replays the latched copy.
        if (gig || rx_ready_q) begin
            cur_rxd = phy_rxd;
            cur_dv  = phy_rx_dv;
            cur_er  = phy_rx_er;
        end else begin
            cur_rxd = rxb_q;
            cur_dv  = rxb_dv_q;
            cur_er  = rxb_er_q;
        end

        rxb_d    = rx_ready_q ? phy_rxd   : rxb_q;
        rxb_dv_d = rx_ready_q ? phy_rx_dv : rxb_dv_q;
        rxb_er_d = rx_ready_q ? phy_rx_er : rxb_er_q;

        ib_nib  = inband_status(full_duplex, spd_q, link_up);
        rxc_hi  = (rx_cnt_q < high_len(spd_q[0]));
        cur_nib = rx_ph_q ? cur_rxd[7:4] : cur_rxd[3:0];

        if (gig) begin
            rxc_1_d    = 1'b1;
            rxc_2_d    = 1'b0;
            rd_1_d     = cur_rxd[3:0];
            rd_2_d     = cur_rxd[7:4];
            rx_ctl_1_d = cur_dv;
            rx_ctl_2_d = cur_dv ^ cur_er;
        end else begin
            // Slow modes: both halves equal, CTL follows the TX_CTL
            // convention per RXC level (dv while high, dv^er while low).
            rxc_1_d    = rxc_hi;
            rxc_2_d    = rxc_hi;
            rd_1_d     = cur_nib;
            rd_2_d     = cur_nib;
            rx_ctl_1_d = rxc_hi ? cur_dv : (cur_dv ^ cur_er);
            rx_ctl_2_d = rxc_hi ? cur_dv : (cur_dv ^ cur_er);
        end

        if (!cur_dv && !cur_er) begin
            rd_1_d = ib_nib;
            rd_2_d = ib_nib;
        end
    end

    // ---------------- TX decode ----------------
    logic       tx_rise;
    logic       nib_en;
    logic       nib_er;

    always_comb begin
        txc_prev_d  = rgmii_txc_1;
        ctl1_prev_d = rgmii_tx_ctl_1;

        // A rising edge of the sampled TXC marks a new nibble; the CTL
        // level just before the edge is EN, the level at the edge gives ER.
        tx_rise = !txc_prev_q && rgmii_txc_1;
        nib_en  = ctl1_prev_q;
        nib_er  = ctl1_prev_q ^ rgmii_tx_ctl_1;

        tx_state_d   = tx_state_q;
        lo_nib_d     = lo_nib_q;
        lo_er_d      = lo_er_q;
        phy_txd_d    = 8'h00;
        phy_tx_en_d  = 1'b0;
        phy_tx_er_d  = 1'b0;
        phy_tx_vld_d = 1'b0;

        if (gig) begin
            phy_txd_d    = {rgmii_txd_2, rgmii_txd_1};
            phy_tx_en_d  = rgmii_tx_ctl_1;
            phy_tx_er_d  = rgmii_tx_ctl_1 ^ rgmii_tx_ctl_2;
            phy_tx_vld_d = 1'b1;
        end else if (tx_rise) begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (nib_en) begin
                        tx_state_d = TX_LO;
                        lo_nib_d   = rgmii_txd_1;
                        lo_er_d    = nib_er;
                    end
                end
                TX_LO: begin
                    tx_state_d   = TX_IDLE;
                    phy_tx_vld_d = 1'b1;
                    phy_tx_en_d  = 1'b1;
                    if (nib_en) begin
                        phy_txd_d   = {rgmii_txd_1, lo_nib_q};
                        phy_tx_er_d = lo_er_q | nib_er;
                    end else begin
                        // Frame ended on an odd nibble: flush it as errored.
                        phy_txd_d   = {4'h0, lo_nib_q};
                        phy_tx_er_d = 1'b1;
                    end
                end
                default: tx_state_d = TX_IDLE;
            endcase
        end

        if (spd_chg) begin
            tx_state_d = TX_IDLE;
        end
    end

    // ---------------- control and output registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spd_q        <= 2'b10;
            rx_cnt_q     <= 6'd0;
            rx_ph_q      <= 1'b0;
            rx_ready_q   <= 1'b0;
            txc_prev_q   <= 1'b0;
            ctl1_prev_q  <= 1'b0;
            tx_state_q   <= TX_IDLE;
            phy_txd_q    <= 8'h00;
            phy_tx_en_q  <= 1'b0;
            phy_tx_er_q  <= 1'b0;
            phy_tx_vld_q <= 1'b0;
            rxc_1_q      <= 1'b1;
            rxc_2_q      <= 1'b0;
            rd_1_q       <= 4'h0;
            rd_2_q       <= 4'h0;
            rx_ctl_1_q   <= 1'b0;
            rx_ctl_2_q   <= 1'b0;
        end else begin
            spd_q        <= spd_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_ph_q      <= rx_ph_d;
            rx_ready_q   <= rx_ready_d;
            txc_prev_q   <= txc_prev_d;
            ctl1_prev_q  <= ctl1_prev_d;
            tx_state_q   <= tx_state_d;
            phy_txd_q    <= phy_txd_d;
            phy_tx_en_q  <= phy_tx_en_d;
            phy_tx_er_q  <= phy_tx_er_d;
            phy_tx_vld_q <= phy_tx_vld_d;
            rxc_1_q      <= rxc_1_d;
            rxc_2_q      <= rxc_2_d;
            rd_1_q       <= rd_1_d;
            rd_2_q       <= rd_2_d;
            rx_ctl_1_q   <= rx_ctl_1_d;
            rx_ctl_2_q   <= rx_ctl_2_d;
        end
    end

    // ---------------- data holding registers ----------------
    always_ff @(posedge clk) begin
        lo_nib_q <= lo_nib_d;
        lo_er_q  <= lo_er_d;
        rxb_q    <= rxb_d;
        rxb_dv_q <= rxb_dv_d;
        rxb_er_q <= rxb_er_d;
    end

    assign phy_txd        = phy_txd_q;
    assign phy_tx_en      = phy_tx_en_q;
    assign phy_tx_er      = phy_tx_er_q;
    assign phy_tx_valid   = phy_tx_vld_q;
    assign phy_rx_ready   = rx_ready_q;
    assign rgmii_rxc_1    = rxc_1_q;
    assign rgmii_rxc_2    = rxc_2_q;
    assign rgmii_rd_1     = rd_1_q;
    assign rgmii_rd_2     = rd_2_q;
    assign rgmii_rx_ctl_1 = rx_ctl_1_q;
    assign rgmii_rx_ctl_2 = rx_ctl_2_q;

endmodule

// File: tb/tb_rgmii_phy_side_if.sv
// Directed bench for rgmii_phy_side_if: 1G TX/RX, 100M RX timing, 100M
// odd-nibble handling, in-band status, speed switching and mid-frame reset.
module tb_rgmii_phy_side_if;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic       link_up, full_duplex;
    logic       rgmii_txc_1;
    logic [3:0] rgmii_txd_1, rgmii_txd_2;
    logic       rgmii_tx_ctl_1, rgmii_tx_ctl_2;
    logic [7:0] phy_txd;
    logic       phy_tx_en, phy_tx_er, phy_tx_valid;
    logic [7:0] phy_rxd;
    logic       phy_rx_dv, phy_rx_er;
    logic       phy_rx_ready;
    logic       rgmii_rxc_1, rgmii_rxc_2;
    logic [3:0] rgmii_rd_1, rgmii_rd_2;
    logic       rgmii_rx_ctl_1, rgmii_rx_ctl_2;

    int n_cmp = 0;
    int n_bad = 0;

    rgmii_phy_side_if dut (
        .clk            (clk),
        .rst            (rst),
        .speed          (speed),
        .link_up        (link_up),
        .full_duplex    (full_duplex),
        .rgmii_txc_1    (rgmii_txc_1),
        .rgmii_txd_1    (rgmii_txd_1),
        .rgmii_txd_2    (rgmii_txd_2),
        .rgmii_tx_ctl_1 (rgmii_tx_ctl_1),
        .rgmii_tx_ctl_2 (rgmii_tx_ctl_2),
        .phy_txd        (phy_txd),
        .phy_tx_en      (phy_tx_en),
        .phy_tx_er      (phy_tx_er),
        .phy_tx_valid   (phy_tx_valid),
        .phy_rxd        (phy_rxd),
        .phy_rx_dv      (phy_rx_dv),
        .phy_rx_er      (phy_rx_er),
        .phy_rx_ready   (phy_rx_ready),
        .rgmii_rxc_1    (rgmii_rxc_1),
        .rgmii_rxc_2    (rgmii_rxc_2),
        .rgmii_rd_1     (rgmii_rd_1),
        .rgmii_rd_2     (rgmii_rd_2),
        .rgmii_rx_ctl_1 (rgmii_rx_ctl_1),
        .rgmii_rx_ctl_2 (rgmii_rx_ctl_2)
    );

    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // One MAC-style 10/100 nibble: lo_cyc cycles of TXC low carrying EN on
    // ctl_1, then hi_cyc (>=3) cycles high with the nibble and EN^ER.
    // v/d/e/r sample the outputs the cycle after the rising edge, v2 the
    // cycle after that.
    task automatic nib(input logic [3:0] n, input logic en, input logic er,
                       input int lo_cyc, input int hi_cyc,
                       output logic v, output logic [7:0] d, output logic e,
                       output logic r, output logic v2);
        for (int k = 0; k < lo_cyc; k++) begin
            @(negedge clk);
            rgmii_txc_1    = 1'b0;
            rgmii_tx_ctl_1 = en;
            rgmii_tx_ctl_2 = en;
            rgmii_txd_1    = 4'h0;
        end
        @(negedge clk);
        rgmii_txc_1    = 1'b1;
        rgmii_txd_1    = n;
        rgmii_tx_ctl_1 = en ^ er;
        rgmii_tx_ctl_2 = en ^ er;
        @(negedge clk);
        v = phy_tx_valid; d = phy_txd; e = phy_tx_en; r = phy_tx_er;
        @(negedge clk);
        v2 = phy_tx_valid;
        for (int k = 3; k < hi_cyc; k++) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       v, e, r, v2, found, exp_rxc;
        logic [7:0] d;
        logic [3:0] exp_rd;

        rst = 1'b1; speed = 2'b10; link_up = 1'b0; full_duplex = 1'b0;
        rgmii_txc_1 = 1'b0; rgmii_txd_1 = 4'h0; rgmii_txd_2 = 4'h0;
        rgmii_tx_ctl_1 = 1'b0; rgmii_tx_ctl_2 = 1'b0;
        phy_rxd = 8'h00; phy_rx_dv = 1'b0; phy_rx_er = 1'b0;

        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_rxc1", rgmii_rxc_1, 1);
        chk("rst_rxc2", rgmii_rxc_2, 0);
        chk("rst_rd1", rgmii_rd_1, 0);
        chk("rst_rd2", rgmii_rd_2, 0);
        chk("rst_ctl1", rgmii_rx_ctl_1, 0);
        chk("rst_ctl2", rgmii_rx_ctl_2, 0);
        chk("rst_txd", phy_txd, 0);
        chk("rst_en", phy_tx_en, 0);
        chk("rst_er", phy_tx_er, 0);
        chk("rst_vld", phy_tx_valid, 0);
        chk("rst_rdy", phy_rx_ready, 0);

        // 1G TX and RX
        rst = 1'b0;
        rgmii_txd_1 = 4'h5; rgmii_txd_2 = 4'hD;
        rgmii_tx_ctl_1 = 1'b1; rgmii_tx_ctl_2 = 1'b1;
        phy_rxd = 8'h3C; phy_rx_dv = 1'b1; full_duplex = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("g_txd", phy_txd, 8'hD5);
            chk("g_en", phy_tx_en, 1);
            chk("g_er", phy_tx_er, 0);
            chk("g_vld", phy_tx_valid, 1);
        end
        chk("g_rd1", rgmii_rd_1, 4'hC);
        chk("g_rd2", rgmii_rd_2, 4'h3);
        chk("g_rxc1", rgmii_rxc_1, 1);
        chk("g_rxc2", rgmii_rxc_2, 0);
        chk("g_rctl1", rgmii_rx_ctl_1, 1);
        chk("g_rctl2", rgmii_rx_ctl_2, 1);
        chk("g_rdy", phy_rx_ready, 1);

        rgmii_tx_ctl_2 = 1'b0; phy_rx_er = 1'b1;
        @(negedge clk);
        chk("g_txer", phy_tx_er, 1);
        chk("g_txen_er", phy_tx_en, 1);
        chk("g_rctl1_er", rgmii_rx_ctl_1, 1);
        chk("g_rctl2_er", rgmii_rx_ctl_2, 0);

        // 1G idle: in-band {fd=1, spd=10, link=0}
        phy_rxd = 8'h21; phy_rx_dv = 1'b0; phy_rx_er = 1'b0;
        @(negedge clk);
        chk("g_ib_rd1", rgmii_rd_1, 4'b1100);
        chk("g_ib_rd2", rgmii_rd_2, 4'b1100);
        chk("g_ib_ctl1", rgmii_rx_ctl_1, 0);

        // 100M RX: bytes 55 then D5
        speed = 2'b01; link_up = 1'b1; full_duplex = 1'b1;
        phy_rxd = 8'h55; phy_rx_dv = 1'b1;
        rgmii_tx_ctl_1 = 1'b0; rgmii_tx_ctl_2 = 1'b0; rgmii_txc_1 = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            exp_rxc = (i == 0) ? 1'b1 : (((i - 1) % 5) < 3);
            exp_rd  = (i <= 15) ? 4'h5 : 4'hD;
            chk("m_rdy", phy_rx_ready, (i == 0 || i == 10 || i == 20) ? 1 : 0);
            chk("m_rxc1", rgmii_rxc_1, exp_rxc);
            chk("m_rxc2", rgmii_rxc_2, (i == 0) ? 1'b0 : exp_rxc);
            chk("m_rd1", rgmii_rd_1, exp_rd);
            chk("m_rd2", rgmii_rd_2, exp_rd);
            chk("m_ctl1", rgmii_rx_ctl_1, 1);
            if (i == 1) phy_rxd = 8'hD5;
            if (i == 11) begin phy_rxd = 8'h00; phy_rx_dv = 1'b0; end
        end
        // 100M idle: in-band {1, 01, 1}
        @(negedge clk);
        chk("m_ib_rd1", rgmii_rd_1, 4'b1011);
        chk("m_ib_rd2", rgmii_rd_2, 4'b1011);
        chk("m_ib_rxc1", rgmii_rxc_1, 1);
        chk("m_ib_ctl1", rgmii_rx_ctl_1, 0);

        // 100M TX: even pair, odd-nibble end, idle, errored pair
        nib(4'hA, 1'b1, 1'b0, 2, 3, v, d, e, r, v2);
        chk("o_n1_vld", v, 0);
        nib(4'h5, 1'b1, 1'b0, 2, 3, v, d, e, r, v2);
        chk("o_n2_vld", v, 1);
        chk("o_n2_txd", d, 8'h5A);
        chk("o_n2_en", e, 1);
        chk("o_n2_er", r, 0);
        chk("o_n2_vld2", v2, 0);
        nib(4'hC, 1'b1, 1'b0, 2, 3, v, d, e, r, v2);
        chk("o_n3_vld", v, 0);
        nib(4'h0, 1'b0, 1'b0, 2, 3, v, d, e, r, v2);
        chk("o_end_vld", v, 1);
        chk("o_end_txd", d, 8'h0C);
        chk("o_end_en", e, 1);
        chk("o_end_er", r, 1);
        nib(4'h0, 1'b0, 1'b0, 2, 3, v, d, e, r, v2);
        chk("o_idle_vld", v, 0);
        chk("o_idle_en", e, 0);
        nib(4'h1, 1'b1, 1'b0, 2, 3, v, d, e, r, v2);
        nib(4'hF, 1'b1, 1'b1, 2, 3, v, d, e, r, v2);
        chk("o_erp_vld", v, 1);
        chk("o_erp_txd", d, 8'hF1);
        chk("o_erp_er", r, 1);

        // 100M -> 1G only at the end of the byte period
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (phy_rx_ready) found = 1'b1;
        end
        chk("sw1_wait_rdy", found, 1);
        speed = 2'b10;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (j == 9)  chk("sw1_rdy9", phy_rx_ready, 0);
            if (j == 10) chk("sw1_rdy10", phy_rx_ready, 1);
            if (j == 10) chk("sw1_rxc10", rgmii_rxc_1, 0);
            if (j == 11) chk("sw1_rdy11", phy_rx_ready, 1);
            if (j == 11) chk("sw1_rxc11", rgmii_rxc_1, 1);
        end

        // 1G -> 10M mid-stream: counter restarts at 0
        speed = 2'b00; phy_rxd = 8'h96; phy_rx_dv = 1'b1; phy_rx_er = 1'b0;
        for (int j = 1; j <= 101; j++) begin
            @(negedge clk);
            if (j == 1)   chk("t_rdy1", phy_rx_ready, 1);
            if (j == 2)   chk("t_rdy2", phy_rx_ready, 0);
            if (j == 2)   chk("t_rd1_lo", rgmii_rd_1, 4'h6);
            if (j == 2)   chk("t_rxc_c0", rgmii_rxc_1, 1);
            if (j == 26)  chk("t_rxc_c24", rgmii_rxc_1, 1);
            if (j == 27)  chk("t_rxc_c25", rgmii_rxc_1, 0);
            if (j == 27)  chk("t_rxc2_c25", rgmii_rxc_2, 0);
            if (j == 52)  chk("t_rd1_hi", rgmii_rd_1, 4'h9);
            if (j == 52)  chk("t_rd2_hi", rgmii_rd_2, 4'h9);
            if (j == 100) chk("t_rdy100", phy_rx_ready, 0);
            if (j == 101) chk("t_rdy101", phy_rx_ready, 1);
        end

        // 10M TX round trip of byte A3
        nib(4'h3, 1'b1, 1'b0, 25, 25, v, d, e, r, v2);
        chk("t10_lo_vld", v, 0);
        nib(4'hA, 1'b1, 1'b0, 25, 25, v, d, e, r, v2);
        chk("t10_vld", v, 1);
        chk("t10_txd", d, 8'hA3);
        chk("t10_en", e, 1);
        chk("t10_er", r, 0);
        chk("t10_vld2", v2, 0);

        // Reset mid-frame: low nibble held, RX byte in flight with RXC high
        nib(4'h7, 1'b1, 1'b0, 25, 3, v, d, e, r, v2);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (rgmii_rxc_2 && rgmii_rd_1 != 4'h0) found = 1'b1;
        end
        chk("mr_wait_rxc", found, 1);
        rst = 1'b1;
        #1;
        chk("mr_rxc1", rgmii_rxc_1, 1);
        chk("mr_rxc2", rgmii_rxc_2, 0);
        chk("mr_rd1", rgmii_rd_1, 0);
        chk("mr_rd2", rgmii_rd_2, 0);
        chk("mr_ctl1", rgmii_rx_ctl_1, 0);
        chk("mr_ctl2", rgmii_rx_ctl_2, 0);
        chk("mr_txd", phy_txd, 0);
        chk("mr_en", phy_tx_en, 0);
        chk("mr_vld", phy_tx_valid, 0);
        chk("mr_rdy", phy_rx_ready, 0);

        // After reset the block is back in 1G
        @(negedge clk);
        rst = 1'b0; speed = 2'b10;
        rgmii_txc_1 = 1'b0; rgmii_txd_1 = 4'h4; rgmii_txd_2 = 4'h2;
        rgmii_tx_ctl_1 = 1'b1; rgmii_tx_ctl_2 = 1'b1;
        @(negedge clk);
        chk("pr_rd1", rgmii_rd_1, 4'h6);
        chk("pr_rd2", rgmii_rd_2, 4'h9);
        chk("pr_rxc2", rgmii_rxc_2, 0);
        chk("pr_rdy", phy_rx_ready, 1);
        chk("pr_txd", phy_txd, 8'h24);
        chk("pr_vld", phy_tx_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
